// File: rtl/out_drain.sv
// Output drain: streams a block of words from the output RAM through a 4-entry FIFO
// onto a valid/ready stream. Reads are issued in order and limited by FIFO credits.
module out_drain #(
    parameter int unsigned VEC_WIDTH = 64,
    parameter int unsigned ARR_DEPTH = 64,
    parameter int unsigned ADDR_W    = 13
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [6:0]           i_len,
    output logic                 o_ram_re,
    output logic [ADDR_W-1:0]    o_ram_addr,
    input  logic [VEC_WIDTH-1:0] i_ram_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [VEC_WIDTH-1:0] o_data,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned       LEN_CAP_INT = (ARR_DEPTH > 127) ? 127 : ARR_DEPTH;
    localparam logic [6:0]        LEN_CAP     = 7'(LEN_CAP_INT);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(ARR_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [6:0]           len_q;
    logic [6:0]           issued_q;
    logic [6:0]           popped_q;
    logic                 rd_pend_q;
    logic [VEC_WIDTH-1:0] fifo_q [4];
    logic [1:0]           wr_ptr_q;
    logic [1:0]           rd_ptr_q;
    logic [2:0]           count_q;

    logic [6:0] eff_len;
    logic       start_ok;
    logic       push;
    logic       pop;

    assign eff_len  = (i_len > LEN_CAP) ? LEN_CAP : i_len;
    assign start_ok = (state_q == StIdle) && i_start;

    // A read is only launched when the FIFO is guaranteed to have room for its data.
    assign o_ram_re   = (state_q == StRun) && (issued_q < len_q) &&
                        ((count_q + {2'b00, rd_pend_q}) < 3'd4);
    assign o_ram_addr = o_ram_re ? rd_addr_q : '0;

    assign push    = rd_pend_q;
    assign o_valid = (count_q != 3'd0);
    assign pop     = o_valid && i_ready;
    assign o_data  = fifo_q[rd_ptr_q];
    assign o_last  = o_valid && (popped_q == len_q - 7'd1);
    assign o_busy  = (state_q == StRun);
    assign o_done  = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = (eff_len != 7'd0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (pop && o_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_addr_q <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            rd_pend_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rd_pend_q <= o_ram_re;

            if (start_ok) begin
                len_q     <= eff_len;
                issued_q  <= '0;
                popped_q  <= '0;
                rd_addr_q <= ADDR_W'(32'(i_base_addr) % ARR_DEPTH);
            end else if (o_ram_re) begin
                issued_q  <= issued_q + 7'd1;
                rd_addr_q <= (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_W'(1);
            end

            if (pop) begin
                popped_q <= popped_q + 7'd1;
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end

            // Read data is captured exactly one cycle after its read enable.
            if (push) begin
                fifo_q[wr_ptr_q] <= i_ram_data;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_out_drain.sv
// Bench for out_drain: behavioural RAM plus a scoreboard of expected addresses and words,
// filled when a drain is started and consumed as the DUT issues reads and handshakes.
module tb_out_drain;

    localparam int unsigned VW = 64;
    localparam int unsigned AD = 64;
    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [6:0]    len;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [VW-1:0] ram_data;
    logic          valid;
    logic          ready;
    logic [VW-1:0] data;
    logic          last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr[$];
    logic [VW-1:0] exp_data[$];
    logic          exp_last[$];

    always #5 clk = ~clk;

    out_drain #(
        .VEC_WIDTH(VW),
        .ARR_DEPTH(AD),
        .ADDR_W   (AW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_base_addr(base),
        .i_len      (len),
        .o_ram_re   (ram_re),
        .o_ram_addr (ram_addr),
        .i_ram_data (ram_data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_data     (data),
        .o_last     (last),
        .o_busy     (busy),
        .o_done     (done)
    );

    function automatic logic [VW-1:0] ram_word(input logic [AW-1:0] a);
        logic [15:0] w;
        w = 16'(a);
        return {16'hA000 ^ w, w * 16'd7, ~w, 16'h5A5A ^ w};
    endfunction

    // RAM returns data one cycle after the read; poison value otherwise.
    always @(posedge clk) ram_data <= ram_re ? ram_word(ram_addr) : {4{16'hDEAD}};

    task automatic clear_sb;
        exp_addr.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic start_drain(input int b, input int l);
        int eff;
        eff = (l > int'(AD)) ? int'(AD) : l;
        @(negedge clk);
        start = 1'b1;
        base  = AW'(b);
        len   = 7'(l);
        for (int k = 0; k < eff; k++) begin
            logic [AW-1:0] a;
            a = AW'((b + k) % int'(AD));
            exp_addr.push_back(a);
            exp_data.push_back(ram_word(a));
            exp_last.push_back(k == eff - 1);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid, last, ram_re, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {valid, last, ram_re, busy, done});
        end
        checks++;
        if (data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", data);
        end
        checks++;
        if (ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", ram_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, ram_re, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL idle_ctrl: got %b want 0000", {valid, ram_re, busy, done});
        end
    endtask

    task automatic test_full_64;
        int n = 0;
        int first_re = 0;
        int done_t = 0;
        int dones = 0;
        logic [VW-1:0] ed;
        logic el;
        logic [AW-1:0] ea;
        ready = 1'b1;
        start_drain(0, 64);
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            checks++;
            if (ram_re !== (t <= 64)) begin
                errors++;
                $display("FAIL full_re_t%0d: got %b want %b", t, ram_re, t <= 64);
            end
            if (ram_re === 1'b1) begin
                if (first_re == 0) first_re = t;
                ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : '1;
                checks++;
                if (ram_addr !== ea) begin
                    errors++;
                    $display("FAIL full_addr_t%0d: got %0d want %0d", t, ram_addr, ea);
                end
            end
            checks++;
            if (busy !== (t <= 66)) begin
                errors++;
                $display("FAIL full_busy_t%0d: got %b want %b", t, busy, t <= 66);
            end
            checks++;
            if (valid !== (t >= 3 && t <= 66)) begin
                errors++;
                $display("FAIL full_valid_t%0d: got %b want %b", t, valid, t >= 3 && t <= 66);
            end
            if (valid === 1'b1 && exp_data.size() > 0) begin
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                checks++;
                if ({last, data} !== {el, ed} || t != n + 3) begin
                    errors++;
                    $display("FAIL full_word%0d: got t=%0d last=%b data=%h want t=%0d last=%b data=%h",
                             n, t, last, data, n + 3, el, ed);
                end
                n++;
            end
            if (done === 1'b1) begin
                dones++;
                if (done_t == 0) done_t = t;
            end
        end
        checks++;
        if (first_re != 1) begin
            errors++;
            $display("FAIL full_first_re: got %0d want 1", first_re);
        end
        checks++;
        if (n != 64 || done_t != 67 || dones != 1) begin
            errors++;
            $display("FAIL full_summary: got words=%0d done_t=%0d dones=%0d want 64 67 1",
                     n, done_t, dones);
        end
        clear_sb();
    endtask

    task automatic test_wrap;
        int n = 0;
        int done_t = 0;
        logic [VW-1:0] ed;
        logic el;
        logic [AW-1:0] ea;
        ready = 1'b1;
        start_drain(60, 8);
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk);
            if (ram_re === 1'b1) begin
                ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : '1;
                checks++;
                if (ram_addr !== ea) begin
                    errors++;
                    $display("FAIL wrap_addr_t%0d: got %0d want %0d", t, ram_addr, ea);
                end
            end
            if (valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrap_extra: got data=%h want none", data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if ({last, data} !== {el, ed}) begin
                        errors++;
                        $display("FAIL wrap_word%0d: got last=%b data=%h want last=%b data=%h",
                                 n, last, data, el, ed);
                    end
                    n++;
                end
            end
            if (done === 1'b1 && done_t == 0) done_t = t;
        end
        checks++;
        if (n != 8 || done_t != 11 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL wrap_summary: got words=%0d done_t=%0d reads_left=%0d want 8 11 0",
                     n, done_t, exp_addr.size());
        end
        clear_sb();
    endtask

    task automatic test_backpressure;
        int n = 0;
        int occ = 0;
        int dones = 0;
        logic re_p1 = 1'b0;
        logic re_p2 = 1'b0;
        logic hs_p1 = 1'b0;
        logic hs;
        logic prev_stall = 1'b0;
        logic prev_last = 1'b0;
        logic [VW-1:0] prev_data = '0;
        logic [VW-1:0] ed;
        logic el;
        logic [AW-1:0] ea;
        ready = 1'b0;
        start_drain(5, 16);
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            occ = occ + int'(re_p2) - int'(hs_p1);
            checks++;
            if (occ + int'(re_p1) > 4) begin
                errors++;
                $display("FAIL bp_credit_t%0d: got %0d want <=4", t, occ + int'(re_p1));
            end
            checks++;
            if (valid !== (occ > 0)) begin
                errors++;
                $display("FAIL bp_valid_t%0d: got %b want %b", t, valid, occ > 0);
            end
            if (prev_stall) begin
                checks++;
                if ({valid, last, data} !== {1'b1, prev_last, prev_data}) begin
                    errors++;
                    $display("FAIL bp_hold_t%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                             t, valid, last, data, prev_last, prev_data);
                end
            end
            if (ram_re === 1'b1) begin
                ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : '1;
                checks++;
                if (ram_addr !== ea) begin
                    errors++;
                    $display("FAIL bp_addr_t%0d: got %0d want %0d", t, ram_addr, ea);
                end
            end
            ready = ($urandom_range(0, 99) < 55);
            hs = (valid === 1'b1) && ready;
            if (hs) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_extra: got data=%h want none", data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if ({last, data} !== {el, ed}) begin
                        errors++;
                        $display("FAIL bp_word%0d: got last=%b data=%h want last=%b data=%h",
                                 n, last, data, el, ed);
                    end
                    n++;
                end
            end
            if (done === 1'b1) begin
                dones++;
                break;
            end
            prev_stall = (valid === 1'b1) && !ready;
            prev_data  = data;
            prev_last  = last;
            re_p2      = re_p1;
            re_p1      = ram_re;
            hs_p1      = hs;
        end
        checks++;
        if (n != 16 || dones != 1 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL bp_summary: got words=%0d dones=%0d left=%0d want 16 1 0",
                     n, dones, exp_data.size());
        end
        ready = 1'b1;
        clear_sb();
    endtask

    task automatic test_len_zero_and_cap;
        int n = 0;
        int done_t = 0;
        logic [VW-1:0] ed;
        logic el;
        ready = 1'b1;
        start_drain(7, 0);
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            checks++;
            if ({ram_re, valid, busy, done} !== {3'b000, t == 1}) begin
                errors++;
                $display("FAIL zero_t%0d: got re/v/busy/done=%b want %b",
                         t, {ram_re, valid, busy, done}, {3'b000, t == 1});
            end
        end
        start_drain(33, 100);
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cap_extra: got data=%h want none", data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if ({last, data} !== {el, ed}) begin
                        errors++;
                        $display("FAIL cap_word%0d: got last=%b data=%h want last=%b data=%h",
                                 n, last, data, el, ed);
                    end
                    n++;
                end
            end
            if (done === 1'b1 && done_t == 0) done_t = t;
        end
        checks++;
        if (n != 64 || done_t != 67) begin
            errors++;
            $display("FAIL cap_summary: got words=%0d done_t=%0d want 64 67", n, done_t);
        end
        clear_sb();
    endtask

    task automatic test_restart_ignored;
        int n = 0;
        int dones = 0;
        int done_t = 0;
        logic [VW-1:0] ed;
        logic el;
        logic [AW-1:0] ea;
        ready = 1'b1;
        start_drain(20, 8);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            start = (t == 4);
            base  = (t == 4) ? AW'(40) : base;
            len   = (t == 4) ? 7'd3 : len;
            if (ram_re === 1'b1) begin
                ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : '1;
                checks++;
                if (ram_addr !== ea) begin
                    errors++;
                    $display("FAIL restart_addr_t%0d: got %0d want %0d", t, ram_addr, ea);
                end
            end
            if (valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL restart_extra: got data=%h want none", data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if ({last, data} !== {el, ed}) begin
                        errors++;
                        $display("FAIL restart_word%0d: got last=%b data=%h want last=%b data=%h",
                                 n, last, data, el, ed);
                    end
                    n++;
                end
            end
            if (done === 1'b1) begin
                dones++;
                if (done_t == 0) done_t = t;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 8 || dones != 1 || done_t != 11) begin
            errors++;
            $display("FAIL restart_summary: got words=%0d dones=%0d done_t=%0d want 8 1 11",
                     n, dones, done_t);
        end
        clear_sb();
    endtask

    task automatic test_reset_mid_run;
        int n = 0;
        int dones = 0;
        logic [VW-1:0] ed;
        logic el;
        ready = 1'b1;
        start_drain(0, 64);
        for (int t = 1; t <= 20 && n < 5; t++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (valid === 1'b1 && exp_data.size() > 0) begin
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                checks++;
                if ({last, data} !== {el, ed}) begin
                    errors++;
                    $display("FAIL rstrun_word%0d: got last=%b data=%h want last=%b data=%h",
                             n, last, data, el, ed);
                end
                n++;
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rstrun_words: got %0d want 5", n);
        end
        @(negedge clk);
        rst   = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, last, ram_re, busy, done} !== 5'b0 || data !== '0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL rstrun_outputs: got ctrl=%b data=%h addr=%h want 0 0 0",
                     {valid, last, ram_re, busy, done}, data, ram_addr);
        end
        rst   = 1'b0;
        ready = 1'b1;
        clear_sb();
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            checks++;
            if ({valid, ram_re, busy, done} !== 4'b0) begin
                errors++;
                $display("FAIL rstrun_after_t%0d: got v/re/busy/done=%b want 0000",
                         t, {valid, ram_re, busy, done});
            end
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rstrun_done: got %0d want 0", dones);
        end
    endtask

    task automatic test_after_reset;
        int n = 0;
        int dones = 0;
        int done_t = 0;
        logic [VW-1:0] ed;
        logic el;
        ready = 1'b1;
        start_drain(2, 4);
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL post_extra: got data=%h want none", data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if ({last, data} !== {el, ed}) begin
                        errors++;
                        $display("FAIL post_word%0d: got last=%b data=%h want last=%b data=%h",
                                 n, last, data, el, ed);
                    end
                    n++;
                end
            end
            if (done === 1'b1) begin
                dones++;
                if (done_t == 0) done_t = t;
            end
        end
        checks++;
        if (n != 4 || dones != 1 || done_t != 7) begin
            errors++;
            $display("FAIL post_summary: got words=%0d dones=%0d done_t=%0d want 4 1 7",
                     n, dones, done_t);
        end
        clear_sb();
    endtask

    initial begin
        test_reset();
        test_full_64();
        test_wrap();
        test_backpressure();
        test_len_zero_and_cap();
        test_restart_ignored();
        test_reset_mid_run();
        test_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_drain.md
OUT_DRAIN -- requirements
Module: out_drain

Interface
REQ-001 SHALL have parameter VEC_WIDTH, default 64, meaning output RAM word width (INT4 x 16).
REQ-002 SHALL have parameter ARR_DEPTH, default 64, meaning output RAM depth in words.
REQ-003 SHALL have parameter ADDR_W, default 13, meaning RAM address width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: i_clk in 1, rising-edge clock; i_rst in 1, synchronous active-high reset.
REQ-005 SHALL have i_start in 1: single-cycle pulse that starts a drain, driven from the matrix-done signal.
REQ-006 SHALL have i_base_addr in ADDR_W: first RAM word to read.
REQ-007 SHALL have i_len in 7: number of words to drain, 0..127.
REQ-008 SHALL have o_ram_re out 1: RAM read enable.
REQ-009 SHALL have o_ram_addr out ADDR_W: RAM read address.
REQ-010 SHALL have i_ram_data in VEC_WIDTH: read data, valid exactly one cycle after o_ram_re.
REQ-011 SHALL have o_valid out 1, i_ready in 1, o_data out VEC_WIDTH and o_last out 1, forming the output stream.
REQ-012 SHALL have o_busy out 1: high from the cycle after an accepted start until done.
REQ-013 SHALL have o_done out 1: single-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on i_start with effective length > 0; IDLE->DONE on i_start with effective length 0; RUN->DONE on the cycle the final handshake occurs; DONE->IDLE after one cycle.
REQ-015 SHALL latch i_base_addr and the effective length only on an accepted start.
REQ-016 SHALL use effective length = min(i_len, ARR_DEPTH).
REQ-017 SHALL ignore i_start while not in IDLE.
REQ-018 SHALL drive o_ram_addr for read k as (base + k) mod ARR_DEPTH, zero-extended to ADDR_W, with k = 0..len-1 issued in order.
REQ-019 SHALL issue a read in a RUN cycle only when reads issued < len and (FIFO occupancy + in-flight reads) < 4, both taken from registered values.
REQ-020 SHALL write returned i_ram_data into a 4-entry FIFO on the cycle after its o_ram_re; the FIFO shall never overflow.
REQ-021 SHALL drive o_valid = FIFO not empty and o_data = FIFO head (registered storage).
REQ-022 SHALL complete a handshake when o_valid and i_ready are both high; the FIFO pops on that edge.
REQ-023 SHALL allow a push and a pop in the same cycle, leaving occupancy unchanged.
REQ-024 SHALL hold o_data and o_last stable while o_valid is high and i_ready is low.
REQ-025 SHALL assert o_last exactly with word len-1.
REQ-026 SHALL pulse o_done for one cycle, in DONE, the cycle after the final handshake (or the cycle after a zero-length start); o_busy shall be low in that cycle.
REQ-027 SHALL achieve, with i_ready held high, first o_ram_re in cycle S+1 and first o_valid in cycle S+3 (start sampled at edge S), then one word per cycle with no bubbles.
REQ-028 SHALL continue issuing reads under back-pressure only while the credit limit permits.

Reset
REQ-029 SHALL, while i_rst is high at a clock edge, set FSM=IDLE and clear the FIFO, counters and in-flight count; o_valid, o_last, o_ram_re, o_busy, o_done and o_data shall reset to 0 and o_ram_addr to 0.
REQ-030 SHALL, on reset mid-RUN, discard any read data returning in the cycle after reset, produce no o_done, and accept the next i_start normally.

Verification
REQ-031 SHALL cover: base=0, len=64, i_ready=1 -> 64 words at addresses 0..63 on consecutive cycles S+3..S+66, o_last at S+66, o_done at S+67.
REQ-032 SHALL cover: base=60, len=8 -> addresses 60,61,62,63,0,1,2,3 in order, with o_last on the 8th word.
REQ-033 SHALL cover: len=16, i_ready toggled randomly -> all 16 words in order, none duplicated, o_data stable while stalled, occupancy+in-flight <= 4 at all times.
REQ-034 SHALL cover: len=0 -> no o_ram_re, o_valid never high, o_done at S+1; len=100 -> exactly 64 words.
REQ-035 SHALL cover: i_start re-pulsed mid-RUN -> ignored; i_rst asserted after 5 words -> all outputs 0 the next cycle, no o_done; a following start with len=4 drains exactly 4 words.
